// File: rtl/simple_proc_core_pkg.sv
// Shared definitions for the simple processor core: widths, opcodes, step encoding.
package simple_proc_core_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned IR_W     = 10;
  localparam int unsigned NUM_REGS = 8;

  localparam logic [3:0] MV  = 4'b0000;
  localparam logic [3:0] MVI = 4'b0001;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

endpackage

// File: rtl/simple_proc_core_if.sv
// Instruction/data input and bus/done output bundle of the processor core.
interface simple_proc_core_if;
  import simple_proc_core_pkg::*;

  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Done;
  logic [DATA_W-1:0] BusWires;

  modport master (output DIN, output Run, input Done, input BusWires);
  modport slave  (input DIN, input Run, output Done, output BusWires);
endinterface

// File: rtl/simple_proc_core_units.sv
// Datapath building blocks: loadable register, add/subtract unit, 3-to-8 decoder.

module regn #(
  parameter int unsigned W = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Load on enable; reset wins over any pending load.
  always_ff @(posedge Clock) begin
    if (Reset)   q <= '0;
    else if (en) q <= d;
  end
endmodule

module addsub
  import simple_proc_core_pkg::*;
(
  input  logic              sub,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] s
);
  // Modulo-2^16 add or subtract, no carry out.
  always_comb s = sub ? (a - b) : (a + b);
endmodule

module dec3to8 (
  input  logic [2:0] w,
  input  logic       en,
  output logic [7:0] y
);
  // One-hot register select.
  always_comb begin
    y = '0;
    if (en) y[w] = 1'b1;
  end
endmodule

// File: rtl/simple_proc_core.sv
// Multi-cycle 16-bit core: step-counter FSM, shared bus mux and register file.
module simple_proc_core
  import simple_proc_core_pkg::*;
(
  input logic          Clock,
  input logic          Reset,
  simple_proc_core_if.slave io
);

  step_t             step, step_next;
  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] r_q [NUM_REGS];
  logic [DATA_W-1:0] a_q, g_q, sum, bus;
  logic [3:0]        opcode;
  logic [7:0]        x_sel, y_sel, r_in, r_out;
  logic              ir_in, a_in, g_in, sub, done, din_out, g_out;

  assign opcode = ir[3:0];

  dec3to8 u_dec_x (.w(ir[6:4]), .en(1'b1), .y(x_sel));
  dec3to8 u_dec_y (.w(ir[9:7]), .en(1'b1), .y(y_sel));

  regn #(.W(IR_W))   u_ir (.Clock, .Reset, .en(ir_in), .d(io.DIN[IR_W-1:0]), .q(ir));
  regn #(.W(DATA_W)) u_a  (.Clock, .Reset, .en(a_in),  .d(bus), .q(a_q));
  regn #(.W(DATA_W)) u_g  (.Clock, .Reset, .en(g_in),  .d(sum), .q(g_q));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    regn #(.W(DATA_W)) u_r (.Clock, .Reset, .en(r_in[i]), .d(bus), .q(r_q[i]));
  end

  addsub u_alu (.sub(sub), .a(a_q), .b(bus), .s(sum));

  // Step counter register.
  always_ff @(posedge Clock) begin
    if (Reset) step <= T0;
    else       step <= step_next;
  end

  // Per-step control: bus source, register enables, ALU mode, Done and next step.
  always_comb begin
    step_next = step;
    ir_in     = 1'b0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    r_in      = '0;
    r_out     = '0;
    din_out   = 1'b0;
    g_out     = 1'b0;
    sub       = 1'b0;
    done      = 1'b0;
    case (step)
      T0: begin
        din_out = 1'b1;
        if (io.Run) begin
          ir_in     = 1'b1;
          step_next = T1;
        end
      end
      T1: begin
        case (opcode)
          MV: begin
            r_out = y_sel;
            r_in  = x_sel;
            done  = 1'b1;
          end
          MVI: begin
            din_out = 1'b1;
            r_in    = x_sel;
            done    = 1'b1;
          end
          ADD, SUB: begin
            r_out     = x_sel;
            a_in      = 1'b1;
            step_next = T2;
          end
          default: begin
            din_out = 1'b1;
            done    = 1'b1;
          end
        endcase
      end
      T2: begin
        r_out     = y_sel;
        g_in      = 1'b1;
        sub       = (opcode == SUB);
        step_next = T3;
      end
      T3: begin
        g_out = 1'b1;
        r_in  = x_sel;
        done  = 1'b1;
      end
    endcase
    if (done) step_next = T0;
  end

  // Priority-free bus: control selects exactly one source per step.
  always_comb begin
    bus = '0;
    if (din_out) bus = bus | io.DIN;
    if (g_out)   bus = bus | g_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (r_out[i]) bus = bus | r_q[i];
    end
  end

  assign io.BusWires = bus;
  assign io.Done     = done & ~Reset;

endmodule

// File: tb/tb_simple_proc_core.sv
// Self-checking bench for simple_proc_core against an instruction-level model.
module tb_simple_proc_core;
  import simple_proc_core_pkg::*;

  logic Clock = 1'b0;
  logic Reset;
  simple_proc_core_if io();

  simple_proc_core dut (.Clock(Clock), .Reset(Reset), .io(io));

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  logic        chk_on = 1'b0;
  logic        exp_done;
  logic        exp_bus_chk;
  logic [15:0] exp_bus;
  string       tag;

  // Architectural view of R0..R7 as the instruction set defines it.
  logic [15:0] m_r [8];

  // Compare DUT outputs with the expectations for the current cycle.
  always @(negedge Clock) begin
    #2;
    if (chk_on) begin
      checks++;
      if (io.Done !== exp_done) begin
        failures++;
        $display("FAIL %s Done got=%b exp=%b", tag, io.Done, exp_done);
      end
      if (exp_bus_chk) begin
        checks++;
        if (io.BusWires !== exp_bus) begin
          failures++;
          $display("FAIL %s BusWires got=%h exp=%h", tag, io.BusWires, exp_bus);
        end
      end
    end
  end

  task automatic cyc(input logic [15:0] din, input logic run, input logic rst,
                     input logic e_done, input logic e_bchk, input logic [15:0] e_bus,
                     input string t);
    @(negedge Clock);
    io.DIN      = din;
    io.Run      = run;
    Reset       = rst;
    exp_done    = e_done;
    exp_bus_chk = e_bchk;
    exp_bus     = e_bus;
    tag         = t;
    chk_on      = 1'b1;
  endtask

  task automatic pin(input string t, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s model got=%h exp=%h", t, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
  endtask

  task automatic do_reset();
    cyc(16'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0, '0, "reset");
    clear_model();
  endtask

  task automatic idle(input logic [15:0] d);
    cyc(d, 1'b0, 1'b0, 1'b0, 1'b1, d, "idle");
  endtask

  // Issue one instruction with Run high in its first cycle; abort_t2 applies reset in T2.
  task automatic exec(input logic [3:0] op, input logic [2:0] x, input logic [2:0] y,
                      input logic [15:0] imm, input logic [5:0] hi, input logic abort_t2,
                      input string t);
    logic [15:0] w, res;
    w = {hi, y, x, op};
    cyc(w, 1'b1, 1'b0, 1'b0, 1'b1, w, {t, "_fetch"});
    if (op == 4'd0) begin
      cyc(16'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b1, m_r[y], {t, "_mv"});
      m_r[x] = m_r[y];
    end else if (op == 4'd1) begin
      cyc(imm, 1'($urandom), 1'b0, 1'b1, 1'b1, imm, {t, "_mvi"});
      m_r[x] = imm;
    end else if (op == 4'd2 || op == 4'd3) begin
      res = (op == 4'd2) ? m_r[x] + m_r[y] : m_r[x] - m_r[y];
      cyc(16'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, m_r[x], {t, "_rdx"});
      if (abort_t2) begin
        do_reset();
      end else begin
        cyc(16'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, m_r[y], {t, "_rdy"});
        cyc(16'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b1, res, {t, "_wb"});
        m_r[x] = res;
      end
    end else begin
      cyc(16'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0, '0, {t, "_nop"});
    end
  endtask

  initial begin
    logic [3:0] op;
    Reset  = 1'b1;
    io.DIN = '0;
    io.Run = 1'b0;
    clear_model();

    do_reset();
    do_reset();
    idle(16'h1234);

    exec(4'd1, 3'd0, 3'd0, 16'h0005, 6'd0, 1'b0, "mvi_r0");
    pin("pin_r0_5", m_r[0], 16'h0005);
    exec(4'd0, 3'd1, 3'd0, '0, 6'd0, 1'b0, "mv_r1_r0");
    pin("pin_r1_5", m_r[1], 16'h0005);
    exec(4'd2, 3'd0, 3'd1, '0, 6'd0, 1'b0, "add_r0_r1");
    pin("pin_r0_a", m_r[0], 16'h000A);

    exec(4'd1, 3'd2, 3'd0, 16'h0003, 6'd0, 1'b0, "mvi_r2");
    exec(4'd1, 3'd3, 3'd0, 16'h0005, 6'd0, 1'b0, "mvi_r3");
    exec(4'd3, 3'd2, 3'd3, '0, 6'd0, 1'b0, "sub_wrap");
    pin("pin_r2_fffe", m_r[2], 16'hFFFE);

    exec(4'd1, 3'd4, 3'd0, 16'hFFFF, 6'd0, 1'b0, "mvi_r4");
    exec(4'd1, 3'd5, 3'd0, 16'h0001, 6'd0, 1'b0, "mvi_r5");
    exec(4'd2, 3'd4, 3'd5, '0, 6'd0, 1'b0, "add_wrap");
    pin("pin_r4_0", m_r[4], 16'h0000);

    exec(4'd2, 3'd2, 3'd2, '0, 6'd0, 1'b0, "add_same");
    pin("pin_r2_fffc", m_r[2], 16'hFFFC);

    idle(16'hBEEF);
    idle(16'h0013);
    idle(16'hFFFF);
    exec(4'd5, 3'd1, 3'd2, '0, 6'd0, 1'b0, "nop5");
    exec(4'd0, 3'd6, 3'd2, '0, 6'd0, 1'b0, "mv_r6_r2");
    pin("pin_r6_fffc", m_r[6], 16'hFFFC);

    exec(4'd1, 3'd7, 3'd0, 16'h0055, 6'd0, 1'b0, "mvi_r7");
    exec(4'd2, 3'd7, 3'd7, '0, 6'd0, 1'b1, "add_abort");
    idle(16'h0A0A);
    exec(4'd0, 3'd0, 3'd7, '0, 6'd0, 1'b0, "mv_r0_r7");
    exec(4'd0, 3'd1, 3'd6, '0, 6'd0, 1'b0, "mv_r1_r6");
    pin("pin_r1_0", m_r[1], 16'h0000);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(9))
        0:       op = 4'($urandom_range(15, 4));
        1, 2:    op = 4'd0;
        3, 4, 5: op = 4'd1;
        6, 7:    op = 4'd2;
        default: op = 4'd3;
      endcase
      exec(op, 3'($urandom), 3'($urandom), 16'($urandom), 6'($urandom),
           1'($urandom_range(39) == 0), "rnd");
      if ($urandom_range(3) == 0) idle(16'($urandom));
    end

    @(negedge Clock);
    chk_on = 1'b0;
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simple_proc_core.md
# simple_proc_core

Minimal 16-bit multi-cycle processor core: an instruction register, eight general registers R0–R7, accumulator A, result register G, a 16-bit add/subtract unit, two 3-to-8 register-select decoders, a bus multiplexer and a 2-bit step counter. Instructions and immediates arrive on DIN. All data moves over a single shared bus, BusWires. This is the execution engine under the system's instruction-fetch/memory logic.

## Interface
- No parameters; data width fixed at 16, IR width 10, eight registers.
- Clock  in  1  single clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- DIN  in  16  instruction word (bits 9:0 used) or immediate operand.
- Run  in  1  start request; sampled only in step T0.
- Done  out  1  high during the final step of an instruction (combinational).
- BusWires  out  16  current shared-bus value.

## Operation
- Instruction fields: I = IR[3:0] opcode; X = IR[6:4] destination/first operand; Y = IR[9:7] source/second operand. X and Y feed two one-hot 3-to-8 decoders.
- Opcodes:
  - 0000 mv Rx←Ry
  - 0001 mvi Rx←DIN (immediate is the DIN word presented during T1)
  - 0010 add Rx←Rx+Ry
  - 0011 sub Rx←Rx−Ry
  - any other opcode is a no-op.
- Step sequence per instruction:
  - T0 (idle/fetch): bus = DIN. If Run=1, IR←DIN[9:0] and advance to T1; otherwise stay in T0 with IR unchanged.
  - T1:
    - mv: bus=Ry, Rx←bus, Done=1.
    - mvi: bus=DIN, Rx←bus, Done=1.
    - add/sub: bus=Rx, A←bus.
    - no-op: Done=1, no writes.
  - T2 (add/sub): bus=Ry, G←A±bus.
  - T3 (add/sub): bus=G, Rx←bus, Done=1.
- Done=1 returns the counter to T0 on the next edge.
- Bus mux is priority-free. Exactly one source is selected per step: DIN, R0–R7, or G. No selection is never used.
- Add/sub: 16-bit modulo 2^16, two's complement, wrap-around, no carry/overflow output. The control input is 0 for add, 1 for subtract. It is driven explicitly in every step (default 0) and is never latched.
- Register enables default to 0 in every step. Only the listed register is written.
- Run is ignored outside T0. Deasserting Run mid-instruction does not abort it.

## Timing
- Reset (synchronous, highest priority): step←T0; IR, R0–R7, A, G ← 0. Done=0 while Reset is high.
- After reset, outputs are: Done=0, BusWires=DIN.
- Latency from the Run edge sampled in T0:
  - mv, mvi, no-op: 2 cycles (T0,T1); Done in T1.
  - add, sub: 4 cycles (T0..T3); Done in T3.
- Back-to-back: Run held high issues the next instruction in the cycle right after Done.
- Written register values are visible on the bus from the cycle after the write edge.
- Reset during T1–T3 abandons the instruction. No partial write occurs at that edge, because reset overrides the enables.
- Same-register operands (X=Y, e.g. add R2,R2) are legal and yield 2·R2 mod 2^16.

## Structure
- Shared package:
  - opcode constants (MV, MVI, ADD, SUB)
  - step encoding (T0–T3, 2-bit)
  - widths (DATA_W=16, IR_W=10)
- Natural sub-modules: addsub (16-bit add/subtract), dec3to8 (one-hot decoder with enable), a loadable register used for R0–R7, A, G and IR (parameterised width). The control FSM and bus mux stay in the top.

## Test plan
- Reset then mvi R0,#5: DIN=0x0001 with Run=1, next cycle DIN=0x0005 → Done in T1, R0=0x0005, total 2 cycles.
- mv R1,R0 (IR=0x0010 with Y=0) after the above → R1=0x0005, Done in T1.
- add R0,R1 with R0=5, R1=5 → G=0x000A in T3 on the bus, R0=0x000A, Done in T3 only.
- sub R2,R3 with R2=0x0003, R3=0x0005 → R2=0xFFFE (wrap). Also add 0xFFFF+0x0001 → 0x0000.
- Reset asserted in T2 of an add → next cycle step=T0, all registers 0, Done=0, destination not written.
- Run low in T0 → IR and registers unchanged, BusWires follows DIN. Opcode 0101 → Done in T1, no register changes.
